// File: rtl/ahb_fir_pkg.sv
// Shared types and constants for the ahb_fir design: AHB encodings and the
// packed instruction layout consumed by ahb_instr_master.
package ahb_fir_pkg;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 32;
    localparam int IWIDTH = DWIDTH + AWIDTH + 6;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HBURST_INCR = 3'b001;

    localparam int I_HWRITE     = IWIDTH - 1;
    localparam int I_HSIZE_MSB  = IWIDTH - 2;
    localparam int I_HSIZE_LSB  = IWIDTH - 4;
    localparam int I_HTRANS_MSB = IWIDTH - 5;
    localparam int I_HTRANS_LSB = IWIDTH - 6;
    localparam int I_ADDR_MSB   = AWIDTH + DWIDTH - 1;
    localparam int I_ADDR_LSB   = DWIDTH;

    typedef struct packed {
        logic              hwrite;
        logic [2:0]        hsize;
        htrans_t           htrans;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } instr_t;

endpackage

// File: rtl/ahb_master_dphase.sv
// Data-phase tracker for ahb_instr_master: follows the transfer in its data
// phase, drives HWDATA, and produces the read-return strobe and error pulse.
module ahb_master_dphase
    import ahb_fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DWIDTH-1:0] hrdata,
    input  logic              ap_valid,
    input  logic              ap_write,
    input  logic [AWIDTH-1:0] ap_addr,
    input  logic [DWIDTH-1:0] ap_wdata,
    output logic              err_first,
    output logic [DWIDTH-1:0] hwdata,
    output logic              amba_wr_flg,
    output logic [AWIDTH-1:0] amba_slv_addr,
    output logic [DWIDTH-1:0] amba_slv_data,
    output logic              amba_err
);

    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [AWIDTH-1:0] dp_addr_q, dp_addr_d;
    logic [DWIDTH-1:0] hwdata_q, hwdata_d;
    logic              wr_flg_q, wr_flg_d;
    logic [AWIDTH-1:0] slv_addr_q, slv_addr_d;
    logic [DWIDTH-1:0] slv_data_q, slv_data_d;
    logic              err_q, err_d;
    logic              rd_done;

    always_comb begin
        err_first  = hresp & ~hready;
        rd_done    = hready & ~hresp & dp_valid_q & ~dp_write_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        hwdata_d   = hwdata_q;
        slv_addr_d = slv_addr_q;
        slv_data_d = slv_data_q;
        wr_flg_d   = rd_done;
        err_d      = err_first;
        if (hready) begin
            dp_valid_d = ap_valid;
            dp_write_d = ap_write;
            dp_addr_d  = ap_addr;
            if (ap_valid && ap_write) begin
                hwdata_d = ap_wdata;
            end
        end
        // An ERROR completion (hresp high) never returns data to the driver.
        if (rd_done) begin
            slv_addr_d = dp_addr_q;
            slv_data_d = hrdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            hwdata_q   <= '0;
            wr_flg_q   <= 1'b0;
            slv_addr_q <= '0;
            slv_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            hwdata_q   <= hwdata_d;
            wr_flg_q   <= wr_flg_d;
            slv_addr_q <= slv_addr_d;
            slv_data_q <= slv_data_d;
            err_q      <= err_d;
        end
    end

    assign hwdata        = hwdata_q;
    assign amba_wr_flg   = wr_flg_q;
    assign amba_slv_addr = slv_addr_q;
    assign amba_slv_data = slv_data_q;
    assign amba_err      = err_q;

endmodule

// File: rtl/ahb_instr_master.sv
// AHB-Lite master that issues one pipelined transfer per packed instruction
// from the bench driver and hands completed reads back as a one-cycle strobe.
module ahb_instr_master
    import ahb_fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              amba_en,
    input  logic [IWIDTH-1:0] amba_instr,
    output logic              instr_rd,
    output logic              amba_wr_flg,
    output logic [AWIDTH-1:0] amba_slv_addr,
    output logic [DWIDTH-1:0] amba_slv_data,
    output logic              amba_err,
    output logic [AWIDTH-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [DWIDTH-1:0] HWDATA,
    input  logic [DWIDTH-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    instr_t            instr;
    logic              err_first;
    logic [AWIDTH-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    htrans_t           htrans_q, htrans_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        instr.hwrite = amba_instr[I_HWRITE];
        instr.hsize  = amba_instr[I_HSIZE_MSB:I_HSIZE_LSB];
        instr.htrans = htrans_t'(amba_instr[I_HTRANS_MSB:I_HTRANS_LSB]);
        instr.addr   = amba_instr[I_ADDR_MSB:I_ADDR_LSB];
        instr.wdata  = amba_instr[DWIDTH-1:0];
    end

    assign instr_rd = amba_en & HREADY & ~err_first;

    always_comb begin
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        htrans_d = htrans_q;
        wdata_d  = wdata_q;
        if (HREADY) begin
            if (instr_rd) begin
                haddr_d  = instr.addr;
                hwrite_d = instr.hwrite;
                hsize_d  = instr.hsize;
                htrans_d = instr.htrans;
                wdata_d  = instr.wdata;
            end else begin
                htrans_d = IDLE;
            end
        end else if (err_first) begin
            // The pending address-phase transfer was already acknowledged to
            // the driver; on ERROR it is dropped rather than retried.
            htrans_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            htrans_q <= IDLE;
            wdata_q  <= '0;
        end else begin
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            htrans_q <= htrans_d;
            wdata_q  <= wdata_d;
        end
    end

    ahb_master_dphase u_dphase (
        .clk           (clk),
        .rst_n         (rst_n),
        .hready        (HREADY),
        .hresp         (HRESP),
        .hrdata        (HRDATA),
        .ap_valid      (htrans_q[1]),
        .ap_write      (hwrite_q),
        .ap_addr       (haddr_q),
        .ap_wdata      (wdata_q),
        .err_first     (err_first),
        .hwdata        (HWDATA),
        .amba_wr_flg   (amba_wr_flg),
        .amba_slv_addr (amba_slv_addr),
        .amba_slv_data (amba_slv_data),
        .amba_err      (amba_err)
    );

    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = hsize_q;
    assign HTRANS = htrans_q;
    assign HBURST = HBURST_INCR;

endmodule
